piso_serializer: RTL and testbench

//  Parallel-in/serial-out shifter; transmit-side counterpart of the 4-bit serial-in shift register.

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 tb/tb_piso_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and zero-gap back-to-back streaming.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             load_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              fill;
    logic              accept;

    // Fill bit shifted in behind the data; with parity it arrives at the output after WIDTH shifts.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v, input logic f);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], f};
        end else begin
            return {f, v[WIDTH-1:1]};
        end
    endfunction

`ifdef PISO_PARITY_EN
    logic par_q, par_d;
    assign fill   = par_q;
    assign last_o = (state_q == StParity);
`else
    assign fill   = 1'b0;
    assign last_o = (state_q == StShift) && (cnt_q == '0);
`endif

    assign load_ready_o = (state_q == StIdle) || last_o;
    assign accept       = load_valid_i && load_ready_o;
    assign x_o          = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
    assign x_valid_o    = busy_q;
    assign busy_o       = busy_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = StShift;
            sreg_d  = load_data_i;
            cnt_d   = CntW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            par_d   = ^load_data_i;
`endif
        end else begin
            unique case (state_q)
                StShift: begin
                    if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                        state_d = StParity;
                        sreg_d  = shift_word(sreg_q, fill);
`else
                        state_d = StIdle;
                        sreg_d  = '0;
`endif
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        sreg_d = shift_word(sreg_q, fill);
                    end
                end
`ifdef PISO_PARITY_EN
                StParity: begin
                    state_d = StIdle;
                    sreg_d  = '0;
                end
`endif
                default: begin
                    state_d = StIdle;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two instances (LSB-first and MSB-first) share stimulus; expected
// serial bits are queued on accept and compared cycle by cycle.
module tb_piso_serializer;

    localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
    localparam bit Par = 1'b1;
`else
    localparam bit Par = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         lv;
    logic [W-1:0] ld;

    logic rdy0, x0, xv0, last0, busy0;
    logic rdy1, x1, xv1, last1, busy1;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (lv),
        .load_data_i  (ld),
        .load_ready_o (rdy0),
        .x_o          (x0),
        .x_valid_o    (xv0),
        .last_o       (last0),
        .busy_o       (busy0)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk          (clk),
        .reset        (reset),
        .load_valid_i (lv),
        .load_data_i  (ld),
        .load_ready_o (rdy1),
        .x_o          (x1),
        .x_valid_o    (xv1),
        .last_o       (last1),
        .busy_o       (busy1)
    );

    always #5 clk = ~clk;

    // Each entry is {x, last} for one frame-bit cycle.
    logic [1:0] q_lsb[$];
    logic [1:0] q_msb[$];
    logic       mdl_rdy;
    int         checks;
    int         errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
            q_lsb.push_back({w[k], (k == W - 1) && !Par});
            q_msb.push_back({w[W-1-k], (k == W - 1) && !Par});
        end
        if (Par) begin
            q_lsb.push_back({^w, 1'b1});
            q_msb.push_back({^w, 1'b1});
        end
    endtask

    task automatic tick();
        logic [1:0] e0, e1;
        logic       v0, v1;
        if (lv && mdl_rdy) push_word(ld);
        @(posedge clk);
        #1;
        v0 = (q_lsb.size() != 0);
        v1 = (q_msb.size() != 0);
        e0 = v0 ? q_lsb.pop_front() : 2'b00;
        e1 = v1 ? q_msb.pop_front() : 2'b00;
        check_eq("lsb_valid", 32'(xv0), 32'(v0));
        check_eq("lsb_busy", 32'(busy0), 32'(v0));
        check_eq("lsb_x", 32'(x0), 32'(e0[1]));
        check_eq("lsb_last", 32'(last0), 32'(e0[0]));
        check_eq("lsb_ready", 32'(rdy0), 32'(!v0 || e0[0]));
        check_eq("msb_valid", 32'(xv1), 32'(v1));
        check_eq("msb_busy", 32'(busy1), 32'(v1));
        check_eq("msb_x", 32'(x1), 32'(e1[1]));
        check_eq("msb_last", 32'(last1), 32'(e1[0]));
        check_eq("msb_ready", 32'(rdy1), 32'(!v1 || e1[0]));
        mdl_rdy = !v0 || e0[0];
    endtask

    task automatic idle(input int n);
        lv = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_x", {30'd0, x0, x1}, 32'd0);
        check_eq("rst_valid", {30'd0, xv0, xv1}, 32'd0);
        check_eq("rst_last", {30'd0, last0, last1}, 32'd0);
        check_eq("rst_busy", {30'd0, busy0, busy1}, 32'd0);
        check_eq("rst_ready", {30'd0, rdy0, rdy1}, 32'd3);
        q_lsb.delete();
        q_msb.delete();
        mdl_rdy = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mdl_rdy = 1'b1;
        lv      = 1'b0;
        ld      = '0;
        assert_reset();
        #20;
        reset = 1'b1;
        idle(1);

        // Reset mid-frame, then a fresh word.
        lv = 1'b1; ld = 4'hF; tick();
        lv = 1'b0; tick();
        assert_reset();
        tick();
        reset = 1'b1;
        lv = 1'b1; ld = 4'h6; tick();
        idle(6);

        // Single word, both bit orders.
        lv = 1'b1; ld = 4'b1011; tick();
        idle(6);

        // Back-to-back with valid held: A then 5.
        lv = 1'b1; ld = 4'hA; tick();
        ld = 4'h5;
        for (int i = 0; i < W - 1 + int'(Par); i++) tick();
        tick();
        idle(7);

        // Load attempt during bit 1 must be ignored.
        lv = 1'b1; ld = 4'h0; tick();
        ld = 4'hF; tick();
        check_eq("busy_ignore_ready", 32'(rdy0), 32'd0);
        idle(7);

        // Parity-sensitive word (even parity 0).
        lv = 1'b1; ld = 4'b0011; tick();
        idle(6);

        // Random valid/data traffic.
        for (int i = 0; i < 40; i++) begin
            lv = 1'($urandom_range(0, 1));
            ld = W'($urandom);
            tick();
        end
        idle(8);

        check_eq("drain_lsb", 32'(q_lsb.size()), 32'd0);
        check_eq("drain_msb", 32'(q_msb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
